// File: rtl/div_8b_pkg.sv
// Shared definitions for the div_8b sequential divider slice.
//   state_t    : controller states (IDLE, CALC, DONE)
//   DEF_WIDTH  : default operand/result width
//   cnt_width  : iteration counter width for a given operand width
package div_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_8b_if.sv
// Start/done handshake bundle for the div_8b divider.
//   start    : request a division (controller -> divider)
//   div1     : dividend (controller -> divider)
//   div2     : divisor  (controller -> divider)
//   quo      : quotient (divider -> controller)
//   resto    : remainder (divider -> controller)
//   fim      : done level (divider -> controller)
//   zero_div : divide-by-zero flag, valid while fim=1 (divider -> controller)
interface div_8b_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] div1;
  logic [WIDTH-1:0] div2;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] resto;
  logic             fim;
  logic             zero_div;

  modport master (
    output start, div1, div2,
    input  quo, resto, fim, zero_div
  );

  modport slave (
    input  start, div1, div2,
    output quo, resto, fim, zero_div
  );

endinterface

// File: rtl/div_8b_step.sv
// One combinational restoring-division step.
//   rem      : current partial remainder (always < divisor)
//   q        : working quotient / remaining dividend bits
//   divisor  : non-zero divisor
//   rem_next : partial remainder after shift and conditional subtract
//   q_next   : working quotient shifted left with the new quotient bit
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] trial;

  // {rem,q} shifted left: the new remainder candidate is {rem, q msb}.
  assign trial = {rem, q[WIDTH-1]} - {1'b0, divisor};

  // rem < divisor keeps both outcomes within WIDTH bits; trial msb is the sign.
  always_comb begin
    rem_next = trial[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], 1'b1};
    if (trial[WIDTH]) begin
      rem_next = {rem[WIDTH-2:0], q[WIDTH-1]};
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_8b.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : div_8b_if slave (start/div1/div2 in; quo/resto/fim/zero_div out)
// Result appears WIDTH+1 edges after the accepting edge; divide-by-zero
// completes on the accepting edge with quo=all ones and resto=dividend.
module div_8b
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  div_8b_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] resto_q, resto_d;
  logic             fim_q, fim_d;
  logic             zdiv_q, zdiv_d;

  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] q_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q        (q_q),
    .divisor  (divisor_q),
    .rem_next (rem_step),
    .q_next   (q_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      q_q       <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      resto_q   <= '0;
      fim_q     <= 1'b0;
      zdiv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      resto_q   <= resto_d;
      fim_q     <= fim_d;
      zdiv_q    <= zdiv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    q_d       = q_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    resto_d   = resto_q;
    fim_d     = fim_q;
    zdiv_d    = zdiv_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          divisor_d = bus.div2;
          rem_d     = '0;
          q_d       = bus.div1;
          cnt_d     = '0;
          quo_d     = '0;
          resto_d   = '0;
          fim_d     = 1'b0;
          zdiv_d    = 1'b0;
          if (bus.div2 == '0) begin
            state_d = DONE;
            quo_d   = '1;
            resto_d = bus.div1;
            zdiv_d  = 1'b1;
            fim_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      // WIDTH step cycles, then one extra cycle to publish the result.
      CALC: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d = DONE;
          quo_d   = q_q;
          resto_d = rem_q;
          fim_d   = 1'b1;
        end else begin
          rem_d = rem_step;
          q_d   = q_step;
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.quo      = quo_q;
  assign bus.resto    = resto_q;
  assign bus.fim      = fim_q;
  assign bus.zero_div = zdiv_q;

endmodule

// File: tb/tb_div_8b.sv
module tb_div_8b;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  div_8b_if #(.WIDTH(8)) bus ();

  div_8b #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive start at the falling edge, return 1ns after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.div1  = a;
    bus.div2  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until fim, bounded; scrambles the operand inputs meanwhile.
  task automatic wait_fim(output int n);
    n = 0;
    while (!bus.fim && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      bus.div1 = 8'($urandom);
      bus.div2 = 8'($urandom);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    int n;
    int ea, eb;
    string t;
    ea = int'(a);
    eb = int'(b);
    t  = $sformatf("%0d/%0d", ea, eb);
    start_op(a, b);
    if (b == 8'd0) begin
      check({t, " fim"}, 32'(bus.fim), 32'd1);
      check({t, " zero_div"}, 32'(bus.zero_div), 32'd1);
      check({t, " quo"}, 32'(bus.quo), 32'd255);
      check({t, " resto"}, 32'(bus.resto), 32'(ea));
    end else begin
      check({t, " fim_drop"}, 32'(bus.fim), 32'd0);
      wait_fim(n);
      check({t, " latency"}, 32'(n), 32'd9);
      check({t, " quo"}, 32'(bus.quo), 32'(ea / eb));
      check({t, " resto"}, 32'(bus.resto), 32'(ea % eb));
      check({t, " zero_div"}, 32'(bus.zero_div), 32'd0);
      check({t, " invariant"}, 32'(int'(bus.quo) * eb + int'(bus.resto)), 32'(ea));
      check({t, " rem_lt_div"}, 32'(int'(bus.resto) < eb), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.div1  = '0;
    bus.div2  = '0;

    #1 reset = 1'b0;
    #1;
    check("rst fim", 32'(bus.fim), 32'd0);
    check("rst quo", 32'(bus.quo), 32'd0);
    check("rst resto", 32'(bus.resto), 32'd0);
    check("rst zero_div", 32'(bus.zero_div), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Directed cases; each starts from DONE after the first.
    do_op(8'd100, 8'd5);
    repeat (3) @(posedge clk);
    #1;
    check("hold fim", 32'(bus.fim), 32'd1);
    check("hold quo", 32'(bus.quo), 32'd20);
    do_op(8'd15, 8'd4);
    do_op(8'd200, 8'd1);
    do_op(8'd7, 8'd9);
    do_op(8'd255, 8'd255);
    do_op(8'd50, 8'd0);

    // 0/10 with a second start pulse while busy: must be ignored.
    start_op(8'd0, 8'd10);
    check("0/10 fim_drop", 32'(bus.fim), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.div1  = 8'd99;
    bus.div2  = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_fim(n);
    check("midstart latency", 32'(n + 4), 32'd9);
    check("midstart quo", 32'(bus.quo), 32'd0);
    check("midstart resto", 32'(bus.resto), 32'd0);
    check("midstart zero_div", 32'(bus.zero_div), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midstart no_queue", 32'(bus.fim), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom), 8'($urandom_range(255, 1)));
    end

    // Reset in the middle of a calculation.
    do_op(8'd200, 8'd3);
    start_op(8'd123, 8'd45);
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check("midrst fim", 32'(bus.fim), 32'd0);
    check("midrst quo", 32'(bus.quo), 32'd0);
    check("midrst resto", 32'(bus.resto), 32'd0);
    check("midrst zero_div", 32'(bus.zero_div), 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("postrst idle fim", 32'(bus.fim), 32'd0);
    do_op(8'd9, 8'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_8b.md
Name: div_8b

Overview:
- Sequential unsigned integer divider: 8-bit dividend `div1` / 8-bit divisor `div2` -> 8-bit quotient `quo` plus 8-bit remainder `resto`.
- Uses restoring (shift-subtract) division, one quotient bit per clock.
- Start/done handshake (`start`/`fim`); divide-by-zero flagged on `zero_div`.
- Arithmetic leaf block inside the datapath; driven by a controller that pulses `start` and waits for `fim`.

Parameters:
- WIDTH, 8, operand/result width in bits (quotient, remainder and iteration count all scale with it).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled on rising clk.
- div1  input  WIDTH  dividend, unsigned; captured when start is accepted.
- div2  input  WIDTH  divisor, unsigned; captured when start is accepted.
- quo  output  WIDTH  quotient, registered.
- resto  output  WIDTH  remainder, registered.
- fim  output  1  done flag, registered; level, not pulse.
- zero_div  output  1  divide-by-zero flag, registered; valid while fim=1.

Behaviour:
- Reset (reset=0, async): state=IDLE; quo, resto, fim, zero_div all 0; internal registers cleared. Outputs stay at reset values until reset is released and a clock edge occurs.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge: capture div1/div2; clear fim, zero_div, quo, resto.
  - If captured divisor==0: go to DONE at that same edge with quo=all ones (8'hFF), resto=div1, zero_div=1, fim=1.
  - Else: load partial remainder=0, work quotient=div1, iteration counter=0; go to CALC.
- CALC, one step per clock:
  - Shift {rem,q} left by 1, then trial = rem - divisor (WIDTH+1 bits).
  - If trial non-negative: rem=trial and q LSB=1; else rem unchanged and q LSB=0.
  - After WIDTH steps, go to DONE, load quo=q and resto=rem, set fim=1.
- Latency: fim rises on the (WIDTH+1)th rising edge after the edge that accepted start (9 cycles for WIDTH=8). Divide-by-zero: fim rises on the accepting edge itself.
- DONE:
  - fim, quo, resto and zero_div hold until the next accepted start.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); fim drops on that edge.
- start while in CALC: ignored; the operation in progress completes undisturbed; no queuing.
- Operands change while busy: no effect; only the values captured at acceptance are used.
- Results: quo = floor(div1/div2) and resto = div1 mod div2 for all div2≠0. The invariant quo*div2 + resto = div1 always holds.
- Dividend 0 gives quo=0, resto=0.
- Reset asserted mid-CALC: immediate abort to IDLE with all outputs 0.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package `div_pkg`:
  - state enum {IDLE, CALC, DONE};
  - default WIDTH=8;
  - counter width = $clog2(WIDTH)+1.
- Sub-module `div_step`: purely combinational one-bit restoring step.
  - Inputs: rem, q, divisor.
  - Outputs: next rem, next q.
  - Instantiated once; the FSM and registers live in div_8b.

Test Plan:
- reset low 2 cycles then high; div1=100, div2=5, start 1 cycle -> fim=1 after 9 edges; quo=20, resto=0, zero_div=0.
- 15/4 started from DONE (back-to-back) -> fim drops on the accepting edge, then quo=3, resto=3, zero_div=0.
- 200/1 -> quo=200, resto=0; also 7/9 -> quo=0, resto=7; 255/255 -> quo=1, resto=0.
- 50/0 -> on the accepting edge: fim=1, zero_div=1, quo=255, resto=50.
- 0/10 -> quo=0, resto=0, zero_div=0; then start re-pulsed mid-CALC with new operands -> ignored, original result returned.
- Random 1000 pairs, div2≠0: check quo*div2+resto==div1 and resto<div2; reset asserted mid-CALC -> all outputs 0 immediately.
